image_pixel_streamer: RTL and testbench

- Downstream consumer of the dual-port 24-bit image ROM (300x300, row-major, 90000 words, 1-cycle registered read; returns zero when the read enable is low).
- On a start pulse it walks the whole image, issues one ROM read per credit, and re-times the ROM's fixed latency into a valid/ready pixel stream with x/y coordinates and line/frame markers.
- It drives one ROM port (clock tied to this block's clock) and feeds display/processing stages that may apply backpressure.

---
 rtl/image_stream_pkg.sv | 25 ++
 rtl/image_pixel_streamer_pixel_fifo.sv | 63 ++++++
 rtl/image_pixel_streamer.sv | 147 ++++++++++++++
 tb/tb_image_pixel_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_stream_pkg.sv
// Shared types and default image geometry for the pixel streaming stages.
package image_stream_pkg;

    localparam int IMAGE_WIDTH       = 300;
    localparam int IMAGE_HEIGHT      = 300;
    localparam int PIXEL_COUNT       = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PIXEL_DATA_WIDTH  = 24;
    localparam int PIXEL_COORD_WIDTH = 9;

    // One buffered pixel: RGB data plus its position and end markers.
    typedef struct packed {
        logic [PIXEL_DATA_WIDTH-1:0]  data;
        logic [PIXEL_COORD_WIDTH-1:0] x;
        logic [PIXEL_COORD_WIDTH-1:0] y;
        logic                         line_last;
        logic                         frame_last;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/image_pixel_streamer_pixel_fifo.sv
// First-word-fall-through FIFO of pixel_t entries with an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo
    import image_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  pixel_t                   push_data,
    input  logic                     pop,
    output pixel_t                   pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    pixel_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage write; the contents are only meaningful below count.
    // NOTE: the array is deliberately left out of reset - count and the
    // pointers already define which entries are live, and an unreset array
    // maps onto plain RAM instead of a flop bank with reset muxes.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count alone.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/image_pixel_streamer.sv
// Walks a row-major image ROM once per start pulse and re-times its one-cycle
// read latency into a valid/ready pixel stream with coordinates and markers.
// Reads are credit-limited so every in-flight ROM word has a FIFO slot waiting.
module image_pixel_streamer #(
    parameter int IMAGE_WIDTH  = 300,
    parameter int IMAGE_HEIGHT = 300,
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_WIDTH   = 17,
    parameter int COORD_WIDTH  = 9,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   rom_read_enable,
    output logic [ADDR_WIDTH-1:0]  rom_address,
    input  logic [DATA_WIDTH-1:0]  rom_read_data,
    output logic [DATA_WIDTH-1:0]  pixel_data,
    output logic [COORD_WIDTH-1:0] pixel_x,
    output logic [COORD_WIDTH-1:0] pixel_y,
    output logic                   pixel_line_last,
    output logic                   pixel_frame_last,
    output logic                   pixel_valid,
    input  logic                   pixel_ready
);

    import image_stream_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDRESS = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_X       = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_Y       = COORD_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [CW:0]            DEPTH_LIMIT  = (CW+1)'(FIFO_DEPTH);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  address;
    logic                   all_issued;
    logic                   pending;
    logic [COORD_WIDTH-1:0] x_count;
    logic [COORD_WIDTH-1:0] y_count;
    logic                   frame_start;
    logic                   pop;
    logic                   issue;
    logic [CW:0]            occupancy;
    logic [CW:0]            limit;
    pixel_t                 push_entry;
    pixel_t                 head;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;

    assign frame_start = (state == IDLE) && start;
    assign pixel_valid = !fifo_empty;
    assign pop         = pixel_valid && pixel_ready;

    // A slot freed by this cycle's pop may be re-granted in the same cycle.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pending};
    assign limit     = DEPTH_LIMIT + {{CW{1'b0}}, pop};
    assign issue     = (state == STREAM) && !all_issued && (occupancy < limit);

    assign rom_read_enable = issue;
    assign rom_address     = address;
    assign busy            = (state == STREAM);
    assign done            = (state == DONE);

    assign push_entry.data       = rom_read_data;
    assign push_entry.x          = x_count;
    assign push_entry.y          = y_count;
    assign push_entry.line_last  = (x_count == LAST_X);
    assign push_entry.frame_last = (x_count == LAST_X) && (y_count == LAST_Y);

    assign pixel_data       = pixel_valid ? head.data       : '0;
    assign pixel_x          = pixel_valid ? head.x          : '0;
    assign pixel_y          = pixel_valid ? head.y          : '0;
    assign pixel_line_last  = pixel_valid && head.line_last;
    assign pixel_frame_last = pixel_valid && head.frame_last;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: the frame ends on the handshake of the frame_last pixel.
    // NOTE: state_next takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (pop && head.frame_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read address walk; holds on the final address once every word is requested.
    always_ff @(posedge clock) begin
        if (reset) begin
            address    <= '0;
            all_issued <= 1'b0;
        end else if (frame_start) begin
            address    <= '0;
            all_issued <= 1'b0;
        end else if (issue) begin
            if (address == LAST_ADDRESS) all_issued <= 1'b1;
            else                         address    <= address + 1'b1;
        end
    end

    // Marks which ROM cycle carries requested data, so idle zeros are never captured.
    always_ff @(posedge clock) begin
        if (reset) pending <= 1'b0;
        else       pending <= issue;
    end

    // Raster position of the next pixel to be pushed.
    always_ff @(posedge clock) begin
        if (reset || frame_start) begin
            x_count <= '0;
            y_count <= '0;
        end else if (pending) begin
            if (x_count == LAST_X) begin
                x_count <= '0;
                y_count <= y_count + 1'b1;
            end else begin
                x_count <= x_count + 1'b1;
            end
        end
    end

    pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (pending),
        .push_data(push_entry),
        .pop      (pop),
        .pop_data (head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Scoreboard bench: each accepted start queues the whole expected frame,
// a negedge monitor pops and compares on every handshake.
module tb_image_pixel_streamer;

    localparam int W     = 7;
    localparam int H     = 5;
    localparam int N     = W * H;
    localparam int DEPTH = 4;
    localparam int AW    = 17;
    localparam int DW    = 24;
    localparam int CWID  = 9;
    localparam int BUDGET = 2000;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic            rom_read_enable;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_read_data;
    logic [DW-1:0]   pixel_data;
    logic [CWID-1:0] pixel_x;
    logic [CWID-1:0] pixel_y;
    logic            pixel_line_last;
    logic            pixel_frame_last;
    logic            pixel_valid;
    logic            pixel_ready;

    always #5 clock = ~clock;

    image_pixel_streamer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .COORD_WIDTH (CWID),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .rom_read_enable (rom_read_enable),
        .rom_address     (rom_address),
        .rom_read_data   (rom_read_data),
        .pixel_data      (pixel_data),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .pixel_line_last (pixel_line_last),
        .pixel_frame_last(pixel_frame_last),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready)
    );

    // Image ROM: registered read, zero when not enabled.
    logic [DW-1:0] rom_mem [N];
    always @(posedge clock) begin
        if (rom_read_enable && int'(rom_address) < N) rom_read_data <= rom_mem[int'(rom_address)];
        else                                          rom_read_data <= '0;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Reference: beat i of a frame is ROM word i at raster position (i mod W, i div W).
    function automatic logic [43:0] model_beat(input int i);
        int x;
        int y;
        x = i % W;
        y = i / W;
        return {rom_mem[i], CWID'(x), CWID'(y), (x == W - 1), (i == N - 1)};
    endfunction

    logic [43:0] exp_q [$];
    logic [43:0] cur_beat;
    assign cur_beat = {pixel_data, pixel_x, pixel_y, pixel_line_last, pixel_frame_last};

    int          done_count = 0;
    int          beats = 0;
    int          reads = 0;
    int          pops  = 0;
    logic        stall_prev = 1'b0;
    logic [43:0] stall_snap;

    // Monitor: scoreboard pops, stream stability, address order and read credit.
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", pixel_valid, 1);
                check("stall_beat_stable", cur_beat, stall_snap);
            end
            if (pixel_valid && pixel_ready) begin
                pops++;
                beats++;
                check("scoreboard_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("beat", cur_beat, exp_q.pop_front());
            end
            if (rom_read_enable) begin
                check("read_address", rom_address, reads);
                reads++;
                check("read_credit", (reads - pops) <= DEPTH, 1);
            end
            if (done) done_count++;
            stall_prev = pixel_valid && !pixel_ready;
            stall_snap = cur_beat;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: always ready; 1: 50% random; 2: random with a 20-cycle stall.
    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 2 && k >= 8 && k < 28) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Pulse start, queue the expected frame and check the fixed start-up latency.
    task automatic launch(input int mode, output int k);
        for (int i = 0; i < N; i++) exp_q.push_back(model_beat(i));
        reads = 0;
        pops  = 0;
        beats = 0;
        start = 1'b1;
        pixel_ready = ready_for(mode, 0);
        tick();
        start = 1'b0;
        k = 1;
        pixel_ready = ready_for(mode, k);
        check("busy_after_start", busy, 1);
        check("first_read_enable", rom_read_enable, 1);
        check("first_read_address", rom_address, 0);
        check("no_valid_k1", pixel_valid, 0);
        tick();
        k = 2;
        pixel_ready = ready_for(mode, k);
        check("no_valid_k2", pixel_valid, 0);
        tick();
        k = 3;
        pixel_ready = ready_for(mode, k);
        check("first_valid_k3", pixel_valid, 1);
        check("first_x", pixel_x, 0);
        check("first_y", pixel_y, 0);
        check("first_data", pixel_data, rom_mem[0]);
    endtask

    // Run until done, optionally pulsing start while busy.
    task automatic run_to_done(input int mode, input bit restarts, inout int k);
        while (!done && k < BUDGET) begin
            tick();
            k++;
            pixel_ready = ready_for(mode, k);
            start = restarts && (k == 5 || k == 12);
        end
        start = 1'b0;
        check("done_within_budget", done, 1);
    endtask

    // Post-frame checks; start is offered in the done cycle and must be ignored.
    task automatic frame_end(input int exp_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("start_in_done_ignored", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("reads_issued", reads, N);
        check("done_pulses", done_count, exp_done);
    endtask

    initial begin
        int k;
        int dc;
        for (int i = 0; i < N; i++) rom_mem[i] = DW'($urandom);
        reset = 1'b1;
        start = 1'b0;
        pixel_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_outputs", {busy, done, rom_read_enable, rom_address, cur_beat, pixel_valid}, 0);
        repeat (6) tick();

        // Frame 1: ready held high, N contiguous beats.
        launch(0, k);
        run_to_done(0, 1'b0, k);
        check("contiguous_done_cycle", k, N + 3);
        frame_end(1);

        // Frame 2: long stall plus random ready, start pulsed while busy.
        launch(2, k);
        run_to_done(2, 1'b1, k);
        frame_end(2);

        // Frame 3: reset in the middle of the frame.
        launch(1, k);
        while (beats < 20 && k < BUDGET) begin
            tick();
            k++;
            pixel_ready = ready_for(1, k);
        end
        check("reached_mid_frame", beats >= 20, 1);
        dc = done_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("reset_busy", busy, 0);
        check("reset_valid", pixel_valid, 0);
        check("reset_read_enable", rom_read_enable, 0);
        check("reset_done", done, 0);
        repeat (3) tick();
        check("no_done_after_reset", done_count, dc);
        check("idle_after_reset", busy, 0);

        // Frame 4: restart from address 0 after reset.
        launch(0, k);
        run_to_done(0, 1'b0, k);
        check("restart_done_cycle", k, N + 3);
        frame_end(dc + 1);

        // Frame 5: start two cycles after done; identical frame and latency.
        tick();
        launch(0, k);
        run_to_done(0, 1'b0, k);
        check("back_to_back_done_cycle", k, N + 3);
        frame_end(dc + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
